// File: rtl/gate_controller_if.sv
// Handshake/bus bundle between the authentication FSM side and the gate controller.
// Carries auth/alarm/sensor inputs and motor/gate/alarm/count outputs.
interface gate_controller_if #(
  parameter int CNT_W = 8
);
  logic             authenticated;
  logic             wrongPinAlarm;
  logic             sensorA;
  logic             sensorB;
  logic             gateState;
  logic             motorUp;
  logic             motorDown;
  logic             blockAlarm;
  logic [CNT_W-1:0] carCount;

  modport master (
    output authenticated,
    output wrongPinAlarm,
    output sensorA,
    output sensorB,
    input  gateState,
    input  motorUp,
    input  motorDown,
    input  blockAlarm,
    input  carCount
  );

  modport slave (
    input  authenticated,
    input  wrongPinAlarm,
    input  sensorA,
    input  sensorB,
    output gateState,
    output motorUp,
    output motorDown,
    output blockAlarm,
    output carCount
  );
endinterface

// File: rtl/gate_controller.sv
// Parking-gate motor/tailgate FSM downstream of PIN authentication.
// Ports: clk, rstN (async low), bus (slave: auth/sensors in, motor/gate/alarm/count out).
module gate_controller #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int OPEN_TIMEOUT  = 16,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rstN,
  gate_controller_if.slave   bus
);
  localparam int MAXC =
    (TRAVEL_CYCLES > OPEN_TIMEOUT) ? TRAVEL_CYCLES : OPEN_TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] TRAV_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_TIMEOUT - 1);

  localparam int I_CLOSED  = 0;
  localparam int I_OPENING = 1;
  localparam int I_OPEN    = 2;
  localparam int I_CLOSING = 3;
  localparam int I_BLOCKED = 4;

  localparam logic [4:0] S_CLOSED  = 5'b00001;
  localparam logic [4:0] S_OPENING = 5'b00010;
  localparam logic [4:0] S_OPEN    = 5'b00100;
  localparam logic [4:0] S_CLOSING = 5'b01000;
  localparam logic [4:0] S_BLOCKED = 5'b10000;

  logic [4:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] car_q, car_d;

  logic both_s, none_s;
  assign both_s = bus.sensorA & bus.sensorB;
  assign none_s = ~bus.sensorA & ~bus.sensorB;

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    unique case (1'b1)
      state_q[I_CLOSED]: begin
        // a held wrong-PIN lockout beats a simultaneous accept
        if (bus.authenticated && !bus.wrongPinAlarm)
          state_d = S_OPENING;
      end
      state_q[I_OPENING]: begin
        if (cnt_q == TRAV_LAST)
          state_d = S_OPEN;
      end
      state_q[I_OPEN]: begin
        if (both_s) begin
          state_d = S_BLOCKED;
        end else if (bus.sensorB) begin
          state_d = S_CLOSING;
          car_d   = car_q + 1'b1;
        end else if (cnt_q == OPEN_LAST) begin
          state_d = S_CLOSING;
        end
      end
      state_q[I_CLOSING]: begin
        if (both_s)
          state_d = S_BLOCKED;
        else if (cnt_q == TRAV_LAST)
          state_d = S_CLOSED;
      end
      state_q[I_BLOCKED]: begin
        if (none_s)
          state_d = S_CLOSING;
      end
      default: state_d = S_CLOSED;
    endcase
  end

  // shared timer restarts on every state change
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_CLOSED;
      cnt_q   <= '0;
      car_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      car_q   <= car_d;
    end
  end

  assign bus.gateState  = ~state_q[I_CLOSED];
  assign bus.motorUp    = state_q[I_OPENING];
  assign bus.motorDown  = state_q[I_CLOSING];
  assign bus.blockAlarm = state_q[I_BLOCKED];
  assign bus.carCount   = car_q;
endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller: timeout, pass, tailgate,
// inhibit, back-to-back, async reset and counter wrap.
module tb_gate_controller;
  logic clk;
  logic rstN;
  int   errors;
  int   checks;

  gate_controller_if #(.CNT_W(8)) b ();
  gate_controller_if #(.CNT_W(2)) b2 ();

  gate_controller #(
    .TRAVEL_CYCLES(4),
    .OPEN_TIMEOUT (16),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (b)
  );

  gate_controller #(
    .TRAVEL_CYCLES(4),
    .OPEN_TIMEOUT (16),
    .CNT_W        (2)
  ) dut2 (
    .clk (clk),
    .rstN(rstN),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gateState, motorUp, motorDown, blockAlarm}
  function automatic logic [3:0] outs();
    return {b.gateState, b.motorUp, b.motorDown, b.blockAlarm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_gate();
    b.authenticated = 1'b1;
    step();
    b.authenticated = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    b.authenticated = 0; b.wrongPinAlarm = 0;
    b.sensorA = 0; b.sensorB = 0;
    b2.authenticated = 0; b2.wrongPinAlarm = 0;
    b2.sensorA = 0; b2.sensorB = 0;
    repeat (2) step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0000", outs());
    end
    checks++;
    if (b.carCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", b.carCount);
    end
    #3 rstN = 1'b1;
    step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL post_release got=%b exp=0000", outs());
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    b.authenticated = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 1) b.authenticated = 1'b0;
      if (n <= 4)       exp = 4'b1100;
      else if (n <= 20) exp = 4'b1000;
      else if (n <= 24) exp = 4'b1010;
      else              exp = 4'b0000;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL timeout_edge%0d got=%b exp=%b", n, outs(), exp);
      end
    end
    checks++;
    if (b.carCount !== 8'd0) begin
      errors++;
      $display("FAIL timeout_count got=%0d exp=0", b.carCount);
    end
  endtask

  task automatic test_car_pass();
    open_gate();
    repeat (3) step();
    checks++;
    if (outs() !== 4'b1000) begin
      errors++;
      $display("FAIL pass_open got=%b exp=1000", outs());
    end
    b.sensorB = 1'b1;
    step();
    b.sensorB = 1'b0;
    checks++;
    if (b.carCount !== 8'd1) begin
      errors++;
      $display("FAIL pass_count got=%0d exp=1", b.carCount);
    end
    for (int n = 1; n <= 4; n++) begin
      checks++;
      if (outs() !== 4'b1010) begin
        errors++;
        $display("FAIL pass_close%0d got=%b exp=1010", n, outs());
      end
      step();
    end
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL pass_closed got=%b exp=0000", outs());
    end
  endtask

  task automatic test_tailgate();
    open_gate();
    b.sensorA = 1'b1;
    b.sensorB = 1'b1;
    repeat (3) step();
    checks++;
    if (outs() !== 4'b1001) begin
      errors++;
      $display("FAIL tail_blocked got=%b exp=1001", outs());
    end
    checks++;
    if (b.carCount !== 8'd1) begin
      errors++;
      $display("FAIL tail_count got=%0d exp=1", b.carCount);
    end
    b.sensorA = 1'b0;
    b.sensorB = 1'b0;
    step();
    repeat (3) step();
    checks++;
    if (outs() !== 4'b1010) begin
      errors++;
      $display("FAIL tail_close4 got=%b exp=1010", outs());
    end
    // last closing cycle: tailgate wins over travel done
    b.sensorA = 1'b1;
    b.sensorB = 1'b1;
    step();
    checks++;
    if (outs() !== 4'b1001) begin
      errors++;
      $display("FAIL tail_prio got=%b exp=1001", outs());
    end
    b.sensorA = 1'b0;
    b.sensorB = 1'b0;
    step();
    repeat (3) step();
    checks++;
    if (outs() !== 4'b1010) begin
      errors++;
      $display("FAIL tail_reclose got=%b exp=1010", outs());
    end
    step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL tail_closed got=%b exp=0000", outs());
    end
  endtask

  task automatic test_inhibit();
    b.authenticated = 1'b1;
    b.wrongPinAlarm = 1'b1;
    repeat (3) step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL inhibit got=%b exp=0000", outs());
    end
    b.authenticated = 1'b0;
    b.wrongPinAlarm = 1'b0;
    step();
    b.authenticated = 1'b1;
    step();
    b.authenticated = 1'b0;
    step();
    b.authenticated = 1'b1;
    step();
    b.authenticated = 1'b0;
    b.wrongPinAlarm = 1'b1;
    step();
    b.wrongPinAlarm = 1'b0;
    checks++;
    if (outs() !== 4'b1100) begin
      errors++;
      $display("FAIL ignore_open4 got=%b exp=1100", outs());
    end
    step();
    checks++;
    if (outs() !== 4'b1000) begin
      errors++;
      $display("FAIL ignore_open got=%b exp=1000", outs());
    end
    repeat (20) step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL ignore_done got=%b exp=0000", outs());
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    b.authenticated = 1'b1;
    repeat (25) step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_closed got=%b exp=0000", outs());
    end
    step();
    b.authenticated = 1'b0;
    checks++;
    if (outs() !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_reopen got=%b exp=1100", outs());
    end
    budget = 0;
    while (b.gateState !== 1'b0 && budget < 40) begin
      step();
      budget++;
    end
    checks++;
    if (budget !== 24) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d exp=24", budget);
    end
  endtask

  task automatic test_async_reset();
    open_gate();
    b.sensorA = 1'b1;
    b.sensorB = 1'b1;
    step();
    checks++;
    if (b.blockAlarm !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got=%b exp=1", b.blockAlarm);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL ar_outs got=%b exp=0000", outs());
    end
    checks++;
    if (b.carCount !== 8'd0) begin
      errors++;
      $display("FAIL ar_count got=%0d exp=0", b.carCount);
    end
    b.sensorA = 1'b0;
    b.sensorB = 1'b0;
    #2 rstN = 1'b1;
    step();
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL ar_after got=%b exp=0000", outs());
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      b2.authenticated = 1'b1;
      step();
      b2.authenticated = 1'b0;
      repeat (4) step();
      b2.sensorB = 1'b1;
      step();
      b2.sensorB = 1'b0;
      exp = 2'(i + 1);
      checks++;
      if (b2.carCount !== exp) begin
        errors++;
        $display("FAIL wrap%0d got=%0d exp=%0d", i, b2.carCount, exp);
      end
      repeat (4) step();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_timeout();
    test_car_pass();
    test_tailgate();
    test_inhibit();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
